valid_latency_tracker: RTL

//  Multi-channel successor to the single-channel data-valid generator.
//  - Tracks the data-valid qualifier of NUM_CH parallel datapath channels, each with its own delay.
//  - Delays are loaded at run time (cfg port), not fixed at build time.
//  - LEVEL mode: warm-up gating. Output asserts after D consecutive valid samples.
//  - PULSE mode: exact tracking. Each input valid pulse re-emerges D edges later.
//  - Sits between a module chain's upstream valid and its downstream consumer (e.g. filter/demod stages).

---
 rtl/valid_latency_tracker.sv | 112 +++++++++++
 1 files changed

// File: rtl/valid_latency_tracker.sv
// Multi-channel data-valid delay tracker.
// Each channel delays its upstream valid by a run-time delay D (1..MAX_DELAY).
// LEVEL mode asserts after D consecutive valid samples; PULSE mode replays
// the valid stream bit-exact D edges later. All state changes on the falling edge.
module valid_latency_tracker #(
  parameter int NUM_CH        = 4,
  parameter int MAX_DELAY     = 16,
  parameter int DEFAULT_DELAY = 2
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  cfg_load,
  input  logic [NUM_CH*$clog2(MAX_DELAY+1)-1:0] cfg_delay,
  input  logic                                  cfg_mode,
  input  logic [NUM_CH-1:0]                     valid_in,
  output logic [NUM_CH-1:0]                     valid_out,
  output logic                                  all_valid,
  output logic                                  cfg_error
);

  localparam int DW = $clog2(MAX_DELAY+1);
  localparam logic [DW-1:0] MAX_D    = DW'(MAX_DELAY);
  localparam logic [DW-1:0] DEF_D    = DW'(DEFAULT_DELAY);
  localparam logic [DW-1:0] DEF_CNT  = DW'(DEFAULT_DELAY - 1);

  logic [DW-1:0]        delay      [NUM_CH];
  logic [DW-1:0]        cnt        [NUM_CH];
  logic [MAX_DELAY-1:0] sr         [NUM_CH];
  logic                 mode;
  logic [NUM_CH-1:0]    validOut;
  logic                 cfgError;

  logic [DW-1:0]        clampDelay [NUM_CH];
  logic                 clampHit;
  logic [DW-1:0]        cntNext    [NUM_CH];
  logic [NUM_CH-1:0]    levelOut;
  logic [MAX_DELAY-1:0] newSr      [NUM_CH];
  logic [NUM_CH-1:0]    pulseBit;

  // Clamp each incoming delay field into 1..MAX_DELAY and flag any correction
  always_comb begin
    clampHit = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      clampDelay[i] = cfg_delay[i*DW +: DW];
      if (clampDelay[i] == '0) begin
        clampDelay[i] = DW'(1);
        clampHit      = 1'b1;
      end else if (clampDelay[i] > MAX_D) begin
        clampDelay[i] = MAX_D;
        clampHit      = 1'b1;
      end
    end
  end

  // Per-channel next state for both the warm-up counter and the pulse history
  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      // LEVEL: count consecutive valid samples, saturating at zero
      if (!valid_in[i]) begin
        cntNext[i]  = delay[i] - DW'(1);
        levelOut[i] = 1'b0;
      end else if (cnt[i] != '0) begin
        cntNext[i]  = cnt[i] - DW'(1);
        levelOut[i] = 1'b0;
      end else begin
        cntNext[i]  = '0;
        levelOut[i] = 1'b1;
      end
      // PULSE: bit j of the updated history is valid_in from j edges ago,
      // so tapping bit D-1 makes a sample reappear after edge k+D-1
      newSr[i]    = (sr[i] << 1) | MAX_DELAY'(valid_in[i]);
      pulseBit[i] = 1'b0;
      for (int unsigned j = 0; j < MAX_DELAY; j++) begin
        if (delay[i] == DW'(j + 1)) pulseBit[i] = newSr[i][j];
      end
    end
  end

  // State update: reset beats config load, config load flushes every channel
  always_ff @(negedge clk) begin
    if (reset) begin
      mode     <= 1'b0;
      cfgError <= 1'b0;
      validOut <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        delay[i] <= DEF_D;
        cnt[i]   <= DEF_CNT;
        sr[i]    <= '0;
      end
    end else if (cfg_load) begin
      mode     <= cfg_mode;
      cfgError <= clampHit;
      validOut <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        delay[i] <= clampDelay[i];
        cnt[i]   <= clampDelay[i] - DW'(1);
        sr[i]    <= '0;
      end
    end else begin
      validOut <= mode ? pulseBit : levelOut;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cnt[i] <= cntNext[i];
        sr[i]  <= newSr[i];
      end
    end
  end

  assign valid_out = validOut;
  assign all_valid = &validOut;
  assign cfg_error = cfgError;

endmodule
